// File: rtl/memu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : memu_pkg
// Brief    : Shared types, func3 encodings and access-legality helper for MEM.
// Revision : 1.0 - initial release
// ============================================================================
package memu_pkg;

    localparam int c_DATAWIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;
    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;

    // Misaligned or unknown-size access; loads take priority if both flags are set.
    function automatic logic mem_access_exc(input logic       is_load,
                                            input logic       is_store,
                                            input logic [2:0] func3,
                                            input logic [1:0] off);
        logic exc;
        exc = 1'b0;
        if (is_load) begin
            case (func3)
                c_F3_LB, c_F3_LBU: exc = 1'b0;
                c_F3_LH, c_F3_LHU: exc = off[0];
                c_F3_LW:           exc = |off;
                default:           exc = 1'b1;
            endcase
        end else if (is_store) begin
            case (func3)
                c_F3_SB: exc = 1'b0;
                c_F3_SH: exc = off[0];
                c_F3_SW: exc = |off;
                default: exc = 1'b1;
            endcase
        end
        return exc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memu_load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Brief    : Selects the addressed byte/halfword of a load word and extends it.
// Revision : 1.0 - initial release
// ============================================================================
module load_align
    import memu_pkg::*;
(
    input  logic [c_DATAWIDTH-1:0] i_rdata,
    input  logic [1:0]             i_off,
    input  logic [2:0]             i_func3,
    output logic [c_DATAWIDTH-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_func3)
            c_F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            c_F3_LBU: o_data = {24'd0, w_byte};
            c_F3_LH:  o_data = {{16{w_half[15]}}, w_half};
            c_F3_LHU: o_data = {16'd0, w_half};
            default:  o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/memu.sv
`default_nettype none
// ============================================================================
// Module   : memu
// Brief    : MEM pipeline stage with single-outstanding data-memory access.
// Revision : 1.0 - initial release
// ============================================================================
module memu
    import memu_pkg::*;
#(
    parameter int DATAWIDTH = c_DATAWIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 es_to_ms_valid,
    output logic                 ms_allowin,
    input  logic [DATAWIDTH-1:0] es_alu_res,
    input  logic [DATAWIDTH-1:0] es_rs2_data,
    input  logic [2:0]           es_func3,
    input  logic                 es_L_type,
    input  logic                 es_S_type,
    input  logic [4:0]           es_rd,
    input  logic                 es_rf_we,
    input  logic                 ws_allowin,
    output logic                 ms_to_ws_valid,
    output logic                 ms_pipe_ready_go,
    output logic [4:0]           ms_rd,
    output logic                 ms_rf_we,
    output logic [DATAWIDTH-1:0] ms_wdata,
    output logic                 ms_mem_exc,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DATAWIDTH-1:0] dmem_addr,
    output logic [3:0]           dmem_wstrb,
    output logic [DATAWIDTH-1:0] dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [DATAWIDTH-1:0] dmem_rdata
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_ms_valid;
    logic [DATAWIDTH-1:0]   r_alu_res;
    logic [DATAWIDTH-1:0]   r_rs2_data;
    logic [DATAWIDTH-1:0]   r_rdata;
    logic [2:0]             r_func3;
    logic                   r_l_type;
    logic                   r_s_type;
    logic [4:0]             r_rd;
    logic                   r_rf_we;
    logic                   r_exc;

    logic                   w_accept;
    logic                   w_es_exc;
    logic                   w_es_mem;
    logic                   w_in_req;
    logic [1:0]             w_off;
    logic [3:0]             w_wstrb;
    logic [DATAWIDTH-1:0]   w_sdata;
    logic [DATAWIDTH-1:0]   w_load_data;

    // Handshake: ready_go depends only on the state register, so no comb loop.
    assign w_in_req         = (r_state == ST_REQ);
    assign ms_pipe_ready_go = ~w_in_req;
    assign ms_allowin       = ~r_ms_valid | (ms_pipe_ready_go & ws_allowin);
    assign ms_to_ws_valid   = r_ms_valid & ms_pipe_ready_go;
    assign w_accept         = es_to_ms_valid & ms_allowin;

    assign w_es_exc = mem_access_exc(es_L_type, es_S_type, es_func3, es_alu_res[1:0]);
    assign w_es_mem = (es_L_type | es_S_type) & ~w_es_exc;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_es_mem ? ST_REQ : ST_IDLE;
                end else if (ws_allowin) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (dmem_ack) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ms_valid <= 1'b0;
            r_alu_res  <= '0;
            r_rs2_data <= '0;
            r_rdata    <= '0;
            r_func3    <= 3'd0;
            r_l_type   <= 1'b0;
            r_s_type   <= 1'b0;
            r_rd       <= 5'd0;
            r_rf_we    <= 1'b0;
            r_exc      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ms_valid <= 1'b1;
                r_alu_res  <= es_alu_res;
                r_rs2_data <= es_rs2_data;
                r_func3    <= es_func3;
                r_l_type   <= es_L_type;
                r_s_type   <= es_S_type;
                r_rd       <= es_rd;
                r_rf_we    <= es_rf_we;
                r_exc      <= w_es_exc;
            end else if (ms_allowin) begin
                r_ms_valid <= 1'b0;
            end
            if (w_in_req && dmem_ack) begin
                r_rdata <= dmem_rdata;
            end
        end
    end

    assign w_off = r_alu_res[1:0];

    // Store lanes: narrow data is replicated so any strobed lane carries it.
    always_comb begin
        w_wstrb = 4'b0000;
        w_sdata = r_rs2_data;
        if (r_s_type) begin
            case (r_func3)
                c_F3_SB: begin
                    w_wstrb = 4'b0001 << w_off;
                    w_sdata = {4{r_rs2_data[7:0]}};
                end
                c_F3_SH: begin
                    w_wstrb = 4'b0011 << w_off;
                    w_sdata = {2{r_rs2_data[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_sdata = r_rs2_data;
                end
            endcase
        end
    end

    assign dmem_req   = w_in_req;
    assign dmem_we    = w_in_req & r_s_type;
    assign dmem_addr  = w_in_req ? {r_alu_res[DATAWIDTH-1:2], 2'b00} : '0;
    assign dmem_wstrb = w_in_req ? w_wstrb : 4'b0000;
    assign dmem_wdata = w_in_req ? w_sdata : '0;

    load_align u_load_align (
        .i_rdata (r_rdata),
        .i_off   (w_off),
        .i_func3 (r_func3),
        .o_data  (w_load_data)
    );

    assign ms_rd      = r_rd;
    assign ms_rf_we   = r_rf_we & ~r_s_type & ~r_exc;
    assign ms_wdata   = r_l_type ? w_load_data : r_alu_res;
    assign ms_mem_exc = r_exc & ms_to_ws_valid;

endmodule
`default_nettype wire

// File: tb/tb_memu.sv
`default_nettype none
// ============================================================================
// Module   : tb_memu
// Brief    : Directed + randomized bench for memu against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_alu_res;
    logic [31:0] es_rs2_data;
    logic [2:0]  es_func3;
    logic        es_L_type;
    logic        es_S_type;
    logic [4:0]  es_rd;
    logic        es_rf_we;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic        ms_pipe_ready_go;
    logic [4:0]  ms_rd;
    logic        ms_rf_we;
    logic [31:0] ms_wdata;
    logic        ms_mem_exc;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    always #5 clk = ~clk;

    memu #(.DATAWIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .es_to_ms_valid   (es_to_ms_valid),
        .ms_allowin       (ms_allowin),
        .es_alu_res       (es_alu_res),
        .es_rs2_data      (es_rs2_data),
        .es_func3         (es_func3),
        .es_L_type        (es_L_type),
        .es_S_type        (es_S_type),
        .es_rd            (es_rd),
        .es_rf_we         (es_rf_we),
        .ws_allowin       (ws_allowin),
        .ms_to_ws_valid   (ms_to_ws_valid),
        .ms_pipe_ready_go (ms_pipe_ready_go),
        .ms_rd            (ms_rd),
        .ms_rf_we         (ms_rf_we),
        .ms_wdata         (ms_wdata),
        .ms_mem_exc       (ms_mem_exc),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_wdata       (dmem_wdata),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural helpers ----------------
    function automatic int acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_exc(input logic l, input logic s, input logic [2:0] f3, input int off);
        bit legal;
        if (!(l || s)) return 0;
        legal = l ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        if (!legal) return 1;
        return (off % acc_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] exp_strb(input logic s, input logic [2:0] f3, input int off);
        logic [3:0] m;
        m = 4'b0000;
        for (int i = 0; i < 4; i++)
            m[i] = s && (i >= off) && (i < off + acc_size(f3));
        return m;
    endfunction

    function automatic logic [31:0] exp_sdata(input logic [31:0] rs2, input logic [2:0] f3);
        logic [31:0] d;
        d = 32'd0;
        for (int i = 0; i < 4; i++)
            d[8*i +: 8] = rs2[8*(i % acc_size(f3)) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [2:0] f3, input int off);
        logic [31:0] v;
        v = w >> (8 * off);
        if (acc_size(f3) == 1) begin
            v = v & 32'h0000_00FF;
            if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (acc_size(f3) == 2) begin
            v = v & 32'h0000_FFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // ---------------- memories (responder side and model side) ----------------
    logic [31:0] resp_mem  [16];
    logic [31:0] model_mem [16];

    int          resp_wait  = -1;
    int          fix_wait   = 0;
    bit          resp_en    = 1'b1;
    logic        auto_ack   = 1'b0;
    logic [31:0] auto_rdata = 32'd0;
    logic        man_ack    = 1'b0;
    logic [31:0] man_rdata  = 32'd0;

    assign dmem_ack   = resp_en ? auto_ack : man_ack;
    assign dmem_rdata = resp_en ? auto_rdata : man_rdata;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            auto_ack   = 1'b0;
            auto_rdata = $urandom;
            if (resp_en && rst_n && dmem_req) begin
                if (resp_wait < 0) resp_wait = (fix_wait >= 0) ? fix_wait : int'($urandom_range(0, 3));
                if (resp_wait == 0) begin
                    auto_ack   = 1'b1;
                    auto_rdata = resp_mem[dmem_addr[5:2]];
                    if (dmem_we)
                        for (int i = 0; i < 4; i++)
                            if (dmem_wstrb[i]) resp_mem[dmem_addr[5:2]][8*i +: 8] = dmem_wdata[8*i +: 8];
                    resp_wait = -1;
                end else begin
                    resp_wait--;
                end
            end else begin
                resp_wait = -1;
            end
        end
    end

    // ---------------- model + per-cycle compare ----------------
    bit          chk_en = 1'b0;
    bit          f_v = 1'b0, f_mem, f_l, f_s, f_exc, f_rfwe, f_acked;
    logic [4:0]  f_rd;
    logic [2:0]  f_f3;
    logic [31:0] f_addr, f_rs2, f_wdata;

    initial begin
        bit exp_ready, exp_out, exp_allow, exp_req;
        int off;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_ready = !f_v || !f_mem || f_acked;
                exp_out   = f_v && exp_ready;
                exp_allow = !f_v || (exp_ready && ws_allowin);
                exp_req   = f_v && f_mem && !f_acked;
                off       = int'(f_addr[1:0]);
                chk("allowin", ms_allowin, exp_allow);
                chk("ready_go", ms_pipe_ready_go, exp_ready);
                chk("to_ws_valid", ms_to_ws_valid, exp_out);
                chk("dmem_req", dmem_req, exp_req);
                chk("mem_exc", ms_mem_exc, exp_out && f_exc);
                if (exp_req) begin
                    chk("req_addr", dmem_addr, {f_addr[31:2], 2'b00});
                    chk("req_we", dmem_we, f_s);
                    chk("req_wstrb", dmem_wstrb, exp_strb(f_s, f_f3, off));
                    if (f_s) chk("req_wdata", dmem_wdata, exp_sdata(f_rs2, f_f3));
                end
                if (exp_out) begin
                    chk("wb_rd", ms_rd, f_rd);
                    chk("wb_rf_we", ms_rf_we, f_rfwe);
                    if (!f_s && !f_exc) chk("wb_wdata", ms_wdata, f_wdata);
                end
                if (!rst_n) begin
                    f_v = 1'b0;
                end else begin
                    if (exp_req && dmem_ack) begin
                        f_acked = 1'b1;
                        if (f_l) begin
                            f_wdata = load_val(model_mem[f_addr[5:2]], f_f3, off);
                        end else begin
                            for (int i = 0; i < acc_size(f_f3); i++)
                                model_mem[f_addr[5:2]][8*(off+i) +: 8] = f_rs2[8*i +: 8];
                        end
                    end
                    if (exp_out && ws_allowin) f_v = 1'b0;
                    if (es_to_ms_valid && exp_allow) begin
                        f_v     = 1'b1;
                        f_l     = es_L_type;
                        f_s     = es_S_type && !es_L_type;
                        f_f3    = es_func3;
                        f_addr  = es_alu_res;
                        f_rs2   = es_rs2_data;
                        f_rd    = es_rd;
                        f_exc   = is_exc(es_L_type, es_S_type, es_func3, int'(es_alu_res[1:0]));
                        f_mem   = (es_L_type || es_S_type) && !f_exc;
                        f_rfwe  = es_rf_we && !f_s && !f_exc;
                        f_wdata = es_alu_res;
                        f_acked = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_instr(input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] f3,
                             input logic l, input logic s, input logic [4:0] rd, input logic we);
        es_alu_res  = alu;
        es_rs2_data = rs2;
        es_func3    = f3;
        es_L_type   = l;
        es_S_type   = s;
        es_rd       = rd;
        es_rf_we    = we;
    endtask

    task automatic send(input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] f3,
                        input logic l, input logic s, input logic [4:0] rd, input logic we);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        set_instr(alu, rs2, f3, l, s, rd, we);
        es_to_ms_valid = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (ms_allowin) ok = 1'b1;
        end
        chk("send_accepted", ok, 1);
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
    endtask

    task automatic wait_load(input string name, input logic [31:0] exp_wdata);
        int req_cnt;
        bit got;
        req_cnt = 0;
        got     = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (dmem_req) begin
                req_cnt++;
                chk({name, "_addr"}, dmem_addr, 32'h0000_0100);
            end
            if (ms_to_ws_valid) got = 1'b1;
        end
        chk({name, "_valid_seen"}, got, 1);
        chk({name, "_req_cycles"}, req_cnt, 4);
        chk({name, "_wdata"}, ms_wdata, exp_wdata);
    endtask

    task automatic rand_instr();
        int kind;
        logic [2:0] f3;
        kind = $urandom_range(0, 9);
        f3   = 3'($urandom_range(0, 7));
        if (kind < 4) begin
            set_instr($urandom, $urandom, f3, 1'b0, 1'b0, 5'($urandom), 1'($urandom));
        end else if (kind < 7) begin
            if ($urandom_range(0, 9) != 0) f3 = (f3[2] && f3[1]) ? 3'b010 : f3;
            set_instr($urandom, $urandom, f3, 1'b1, 1'b0, 5'($urandom), 1'($urandom));
        end else begin
            if ($urandom_range(0, 9) != 0) f3 = {1'b0, (f3[1] && f3[0]) ? 2'b10 : f3[1:0]};
            set_instr($urandom, $urandom, f3, 1'b0, 1'b1, 5'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        bit got, took;
        logic [31:0] v;
        rst_n          = 1'b0;
        es_to_ms_valid = 1'b0;
        ws_allowin     = 1'b1;
        set_instr(32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            v            = $urandom;
            resp_mem[i]  = v;
            model_mem[i] = v;
        end
        resp_mem[0]  = 32'h80AA_BBCC;
        model_mem[0] = 32'h80AA_BBCC;
        resp_mem[1]  = 32'h1122_3344;
        model_mem[1] = 32'h1122_3344;

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_allowin", ms_allowin, 1);
        chk("rst_ready_go", ms_pipe_ready_go, 1);
        chk("rst_to_ws_valid", ms_to_ws_valid, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_wdata", ms_wdata, 0);
        chk("rst_rf_we", ms_rf_we, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADD: valid the cycle after accept, no memory request
        send(32'h0000_1234, 32'd0, 3'b000, 1'b0, 1'b0, 5'd5, 1'b1);
        @(negedge clk);
        chk("add_valid", ms_to_ws_valid, 1);
        chk("add_wdata", ms_wdata, 32'h0000_1234);
        chk("add_rd", ms_rd, 5);
        chk("add_rf_we", ms_rf_we, 1);
        chk("add_no_req", dmem_req, 0);

        // LB / LBU at 0x103 with three wait cycles
        fix_wait = 3;
        send(32'h0000_0103, 32'd0, 3'b000, 1'b1, 1'b0, 5'd7, 1'b1);
        wait_load("lb", 32'hFFFF_FF80);
        send(32'h0000_0103, 32'd0, 3'b100, 1'b1, 1'b0, 5'd7, 1'b1);
        wait_load("lbu", 32'h0000_0080);

        // SH at 0x202, zero-wait ack
        fix_wait = 0;
        send(32'h0000_0202, 32'hDEAD_BEEF, 3'b001, 1'b0, 1'b1, 5'd9, 1'b1);
        @(negedge clk);
        chk("sh_req", dmem_req, 1);
        chk("sh_we", dmem_we, 1);
        chk("sh_addr", dmem_addr, 32'h0000_0200);
        chk("sh_wstrb", dmem_wstrb, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        @(negedge clk);
        chk("sh_valid", ms_to_ws_valid, 1);
        chk("sh_rf_we", ms_rf_we, 0);

        // Misaligned LW
        send(32'h0000_0301, 32'd0, 3'b010, 1'b1, 1'b0, 5'd3, 1'b1);
        @(negedge clk);
        chk("lwx_valid", ms_to_ws_valid, 1);
        chk("lwx_exc", ms_mem_exc, 1);
        chk("lwx_rf_we", ms_rf_we, 0);
        chk("lwx_no_req", dmem_req, 0);

        // Back-pressure on a finished LW with an ADD waiting behind it
        @(posedge clk);
        #1;
        ws_allowin = 1'b0;
        send(32'h0000_0304, 32'd0, 3'b010, 1'b1, 1'b0, 5'd4, 1'b1);
        set_instr(32'h0000_ABCD, 32'd0, 3'b000, 1'b0, 1'b0, 5'd6, 1'b1);
        es_to_ms_valid = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (ms_to_ws_valid) got = 1'b1;
        end
        chk("bp_valid_seen", got, 1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            chk("bp_valid", ms_to_ws_valid, 1);
            chk("bp_allowin", ms_allowin, 0);
            chk("bp_wdata", ms_wdata, 32'h1122_3344);
            chk("bp_rd", ms_rd, 4);
        end
        @(posedge clk);
        #1;
        ws_allowin = 1'b1;
        @(negedge clk);
        chk("bp_release_allowin", ms_allowin, 1);
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("bp_add_valid", ms_to_ws_valid, 1);
        chk("bp_add_wdata", ms_wdata, 32'h0000_ABCD);
        chk("bp_add_rd", ms_rd, 6);

        // Reset during the second REQ cycle, stray ack afterwards
        resp_en = 1'b0;
        send(32'h0000_0308, 32'd0, 3'b010, 1'b1, 1'b0, 5'd8, 1'b1);
        @(negedge clk);
        chk("rr_req1", dmem_req, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rr_req2", dmem_req, 1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        man_ack   = 1'b1;
        man_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        chk("rr_req_dropped", dmem_req, 0);
        chk("rr_no_valid", ms_to_ws_valid, 0);
        chk("rr_allowin", ms_allowin, 1);
        @(posedge clk);
        #1;
        man_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rr_still_idle", ms_to_ws_valid, 0);
        end
        @(posedge clk);
        #1;
        resp_en  = 1'b1;
        fix_wait = -1;

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            took = es_to_ms_valid && ms_allowin;
            @(posedge clk);
            #1;
            ws_allowin = ($urandom_range(0, 9) < 7);
            if (!es_to_ms_valid || took) begin
                rand_instr();
                es_to_ms_valid = ($urandom_range(0, 9) < 6);
            end
        end
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
        ws_allowin     = 1'b1;
        repeat (10) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
